// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, ALU operation and FSM state types for the multi-cycle RV32I core.
package rv_pkg;
    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
endpackage

// File: rtl/rv_regfile.sv
// rv_regfile: 32 x XLEN register file, two async read ports, one sync write port, x0 reads zero.
module rv_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] r_mem [32];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) r_mem[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : r_mem[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : r_mem[raddr2];
endmodule

// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: five-state multi-cycle RV32I subset core with req/ready memory ports.
// Optional PERF_CNT_EN adds saturating cycle_cnt / instret_cnt outputs.
module rv_multicycle_core
    import rv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [31:0]     HALT_INSTR = 32'h0000_0073
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [PC_W-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic            retire,
    output logic            halted,
    output logic            err,
`ifdef PERF_CNT_EN
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt,
`endif
    output logic [PC_W-1:0] dbg_pc
);
    state_t          r_state, w_next;
    alu_op_t         r_aluop, w_aluop;
    logic [PC_W-1:0] r_pc, w_pc4, w_pcimm, w_pcnext;
    logic [31:0]     r_ir, w_imm32;
    logic [XLEN-1:0] r_a, r_b, r_imm, r_alu, r_mdr;
    logic [XLEN-1:0] w_rs1, w_rs2, w_opb, w_alu, w_wdata;
    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic            r_err, w_legal, w_we, w_taken;

    assign w_opc = r_ir[6:0];
    assign w_f3  = r_ir[14:12];
    assign w_f7  = r_ir[31:25];

    rv_regfile #(.XLEN(XLEN)) u_rf (
        .clk    (clk),
        .we     (w_we),
        .waddr  (r_ir[11:7]),
        .wdata  (w_wdata),
        .raddr1 (r_ir[19:15]),
        .raddr2 (r_ir[24:20]),
        .rdata1 (w_rs1),
        .rdata2 (w_rs2)
    );

    // Decode: legality, ALU op and the 32-bit immediate for each format
    always_comb begin
        w_legal = 1'b1;
        w_aluop = ALU_ADD;
        w_imm32 = {{20{r_ir[31]}}, r_ir[31:20]};
        case (w_opc)
            OP_R: begin
                w_aluop = (w_f7 == 7'h20) ? ALU_SUB : (w_f3 == 3'b111) ? ALU_AND :
                          (w_f3 == 3'b110) ? ALU_OR : (w_f3 == 3'b010) ? ALU_SLT : ALU_ADD;
                w_legal = (w_f7 == 7'h00 && (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110 || w_f3 == 3'b010))
                       || (w_f7 == 7'h20 && w_f3 == 3'b000);
            end
            OP_I:  w_legal = (w_f3 == 3'b000);
            OP_LW: w_legal = (w_f3 == 3'b010);
            OP_SW: begin
                w_legal = (w_f3 == 3'b010);
                w_imm32 = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            end
            OP_BR: begin
                w_legal = (w_f3[2:1] == 2'b00);
                w_imm32 = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            end
            OP_JAL: w_imm32 = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            default: w_legal = 1'b0;
        endcase
    end

    assign w_opb   = (w_opc == OP_R) ? r_b : r_imm;
    assign w_alu   = (r_aluop == ALU_SUB) ? r_a - w_opb :
                     (r_aluop == ALU_AND) ? r_a & w_opb :
                     (r_aluop == ALU_OR)  ? r_a | w_opb :
                     (r_aluop == ALU_SLT) ? XLEN'($signed(r_a) < $signed(w_opb)) : r_a + w_opb;
    assign w_pc4   = r_pc + PC_W'(4);
    assign w_pcimm = r_pc + r_imm[PC_W-1:0];
    assign w_taken = (r_a == r_b) ^ w_f3[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_next;
    end

    // Next state plus all handshake/retire/writeback controls; reset forces them low at once
    always_comb begin
        w_next   = r_state;
        w_pcnext = r_pc;
        w_we     = 1'b0;
        w_wdata  = r_alu;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) w_next = (imem_rdata == HALT_INSTR) ? HALT : DECODE;
            end
            DECODE: w_next = w_legal ? EXEC : HALT;
            EXEC: begin
                if (w_opc == OP_BR) begin
                    w_pcnext = w_taken ? w_pcimm : w_pc4;
                    retire   = 1'b1;
                    w_next   = FETCH;
                end else if (w_opc == OP_JAL) begin
                    w_pcnext = w_pcimm;
                    w_we     = 1'b1;
                    w_wdata  = XLEN'(w_pc4);
                    retire   = 1'b1;
                    w_next   = FETCH;
                end else begin
                    w_next = (w_opc == OP_LW || w_opc == OP_SW) ? MEM : WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_opc == OP_SW);
                if (dmem_ready) begin
                    w_next   = (w_opc == OP_SW) ? FETCH : WB;
                    retire   = (w_opc == OP_SW);
                    w_pcnext = (w_opc == OP_SW) ? w_pc4 : r_pc;
                end
            end
            WB: begin
                w_we     = 1'b1;
                w_wdata  = (w_opc == OP_LW) ? r_mdr : r_alu;
                w_pcnext = w_pc4;
                retire   = 1'b1;
                w_next   = FETCH;
            end
            default: w_next = HALT;
        endcase
        if (!rst_n) begin
            w_we     = 1'b0;
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            retire   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
            r_aluop <= ALU_ADD;
            r_err   <= 1'b0;
        end else begin
            r_pc <= w_pcnext;
            if (r_state == FETCH && imem_ready) r_ir <= imem_rdata;
            if (r_state == DECODE) begin
                r_a     <= w_rs1;
                r_b     <= w_rs2;
                r_imm   <= XLEN'($signed(w_imm32));
                r_aluop <= w_aluop;
                if (!w_legal) r_err <= 1'b1;
            end
            if (r_state == EXEC) r_alu <= w_alu;
            if (r_state == MEM && dmem_ready) r_mdr <= dmem_rdata;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (r_state != HALT && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + XLEN'(1);
            if (retire && !(&instret_cnt)) instret_cnt <= instret_cnt + XLEN'(1);
        end
    end
`endif

    assign imem_addr  = r_pc;
    assign dmem_addr  = r_alu[PC_W-1:0];
    assign dmem_wdata = r_b;
    assign halted     = (r_state == HALT);
    assign err        = r_err;
    assign dbg_pc     = r_pc;
endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb_rv_multicycle_core: table-driven ALU programs plus directed sequences for memory waits,
// branches, jal wrap, halt/illegal and reset during a data access.
module tb_rv_multicycle_core;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted, err;
    logic [7:0]  imem_addr, dmem_addr, dbg_pc;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    int          iwait = 0, dwait = 0, icnt, dcnt, cyc = 0, ret_cnt, st_cnt;
    logic [7:0]  st_addr;
    logic [31:0] st_data;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [31:0] op;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [9];

    always #5 clk = ~clk;

    rv_multicycle_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .retire     (retire),
        .halted     (halted),
        .err        (err),
        .dbg_pc     (dbg_pc)
    );

    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem[dmem_addr[7:2]];
    assign imem_ready = (icnt >= iwait);
    assign dmem_ready = (dcnt >= dwait);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt    <= 0;
            dcnt    <= 0;
            ret_cnt <= 0;
            st_cnt  <= 0;
            st_addr <= '0;
            st_data <= 32'hDEAD_BEEF;
        end else begin
            icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
            if (retire) ret_cnt <= ret_cnt + 1;
            if (dmem_req && dmem_ready && dmem_we) begin
                dmem[dmem_addr[7:2]] <= dmem_wdata;
                st_cnt  <= st_cnt + 1;
                st_addr <= dmem_addr;
                st_data <= dmem_wdata;
            end
        end
    end

    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, OP_I};
    endfunction
    function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction
    function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, OP_LW};
    endfunction
    function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
    endfunction
    function automatic logic [31:0] f_br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
    endfunction
    function automatic logic [31:0] f_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clr_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0073;
    endtask

    task automatic run(output bit done);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            done = halted;
        end
    endtask

    initial begin
        bit          done, found, stable, we0, seen;
        int          t0, t1, n;
        logic [31:0] br_op [4];
        logic [7:0]  br_pc [4];
        logic [31:0] bad_op [3];
        vt[0] = '{12'd5,   12'd7,   f_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), 32'd12};
        vt[1] = '{12'd5,   12'd7,   f_r(7'h20, 3'b000, 5'd3, 5'd1, 5'd2), 32'hFFFF_FFFE};
        vt[2] = '{12'h6A5, 12'h3C3, f_r(7'h00, 3'b111, 5'd3, 5'd1, 5'd2), 32'h0000_0281};
        vt[3] = '{12'h6A5, 12'h3C3, f_r(7'h00, 3'b110, 5'd3, 5'd1, 5'd2), 32'h0000_07E7};
        vt[4] = '{12'hFFF, 12'h001, f_r(7'h00, 3'b010, 5'd3, 5'd1, 5'd2), 32'd1};
        vt[5] = '{12'h001, 12'hFFF, f_r(7'h00, 3'b010, 5'd3, 5'd1, 5'd2), 32'd0};
        vt[6] = '{12'h800, 12'h7FF, f_r(7'h20, 3'b000, 5'd3, 5'd1, 5'd2), 32'hFFFF_F001};
        vt[7] = '{12'hFFF, 12'h000, f_addi(5'd3, 5'd1, 12'd1),           32'd0};
        vt[8] = '{12'hFFF, 12'hFFF, f_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), 32'hFFFF_FFFE};
        clr_imem();
        #12;
        chk("reset_ctrl", {26'd0, imem_req, dmem_req, dmem_we, retire, halted, err}, 32'd0);
        chk("reset_pc", {24'd0, dbg_pc}, 32'd0);

        foreach (vt[v]) begin
            clr_imem();
            imem[0] = f_addi(5'd1, 5'd0, vt[v].a);
            imem[1] = f_addi(5'd2, 5'd0, vt[v].b);
            imem[2] = vt[v].op;
            imem[3] = f_sw(5'd3, 5'd0, 12'd64);
            run(done);
            chk($sformatf("vec%0d_halt", v), {31'd0, done}, 32'd1);
            chk($sformatf("vec%0d_result", v), st_data, vt[v].exp);
            chk($sformatf("vec%0d_retires", v), 32'(ret_cnt), 32'd4);
        end
        chk("vec_store_addr", {24'd0, st_addr}, 32'd64);

        // ALU latency from start of fetch to retire, with and without fetch wait states
        for (int w = 0; w <= 2; w += 2) begin
            clr_imem();
            iwait = w;
            imem[0] = f_addi(5'd1, 5'd0, 12'd5);
            imem[1] = f_addi(5'd2, 5'd0, 12'd7);
            imem[2] = f_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            t0 = 0;
            t1 = -100;
            found = 1'b0;
            for (int k = 0; k < 60 && !found; k++) begin
                @(negedge clk);
                if (imem_req && imem_addr == 8'h08) begin found = 1'b1; t0 = cyc; end
            end
            found = 1'b0;
            for (int k = 0; k < 60 && !found; k++) begin
                @(negedge clk);
                if (retire) begin found = 1'b1; t1 = cyc; end
            end
            chk($sformatf("add_latency_w%0d", w), 32'(t1 - t0), 32'(3 + w));
            done = 1'b0;
            for (int k = 0; k < 60 && !done; k++) begin @(negedge clk); done = halted; end
            chk($sformatf("lat_retires_w%0d", w), 32'(ret_cnt), 32'd3);
            seen = 1'b0;
            repeat (4) begin @(negedge clk); seen |= imem_req | retire; end
            chk($sformatf("halt_quiet_w%0d", w), {31'd0, seen}, 32'd0);
        end
        iwait = 0;

        // Store then load with two wait states per data access
        clr_imem();
        dwait = 2;
        imem[0] = f_addi(5'd3, 5'd0, 12'd12);
        imem[1] = f_sw(5'd3, 5'd0, 12'd16);
        imem[2] = f_lw(5'd4, 5'd0, 12'd16);
        imem[3] = f_sw(5'd4, 5'd0, 12'd20);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int acc = 0; acc < 2; acc++) begin
            found = 1'b0;
            for (int k = 0; k < 60 && !found; k++) begin @(negedge clk); found = dmem_req; end
            we0 = dmem_we;
            stable = 1'b1;
            for (n = 0; n < 20 && dmem_req; n++) begin
                if (dmem_addr != 8'd16) stable = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("mem%0d_req_cycles", acc), 32'(n), 32'd3);
            chk($sformatf("mem%0d_addr_stable", acc), {31'd0, stable}, 32'd1);
            chk($sformatf("mem%0d_we", acc), {31'd0, we0}, (acc == 0) ? 32'd1 : 32'd0);
        end
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin @(negedge clk); done = halted; end
        chk("lw_value", st_data, 32'd12);
        chk("lw_store_addr", {24'd0, st_addr}, 32'd20);
        chk("mem_retires", 32'(ret_cnt), 32'd4);
        dwait = 0;

        // Branches at 0x20 with offset -8: taken lands on 0x18, not taken on 0x24
        br_op[0] = f_br(3'b000, 5'd1, 5'd1, 13'h1FF8); br_pc[0] = 8'h18;
        br_op[1] = f_br(3'b001, 5'd1, 5'd1, 13'h1FF8); br_pc[1] = 8'h24;
        br_op[2] = f_br(3'b001, 5'd1, 5'd2, 13'h1FF8); br_pc[2] = 8'h18;
        br_op[3] = f_br(3'b000, 5'd1, 5'd2, 13'h1FF8); br_pc[3] = 8'h24;
        for (int b = 0; b < 4; b++) begin
            clr_imem();
            imem[0] = f_addi(5'd1, 5'd0, 12'd3);
            imem[1] = f_addi(5'd2, 5'd0, 12'd4);
            imem[2] = f_jal(5'd0, 21'd24);
            imem[8] = br_op[b];
            run(done);
            chk($sformatf("br%0d_next_pc", b), {24'd0, dbg_pc}, {24'd0, br_pc[b]});
            chk($sformatf("br%0d_retires", b), 32'(ret_cnt), 32'd4);
        end

        // jal from 0x04 back to 0xFC, then jal x1,+12 wraps to 0x08 with link 0x00
        clr_imem();
        imem[0]  = f_addi(5'd1, 5'd0, 12'd9);
        imem[1]  = f_jal(5'd0, 21'h1FFFF8);
        imem[63] = f_jal(5'd1, 21'd12);
        imem[2]  = f_sw(5'd1, 5'd0, 12'd32);
        run(done);
        chk("jal_link", st_data, 32'd0);
        chk("jal_store_addr", {24'd0, st_addr}, 32'd32);
        chk("jal_halt_pc", {24'd0, dbg_pc}, 32'h0C);
        chk("jal_retires", 32'(ret_cnt), 32'd4);

        clr_imem();
        run(done);
        chk("halt_state", {30'd0, halted, err}, 32'b10);
        chk("halt_no_retire", 32'(ret_cnt), 32'd0);
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= imem_req; end
        chk("halt_no_fetch", {31'd0, seen}, 32'd0);

        bad_op[0] = 32'h0000_007F;
        bad_op[1] = f_r(7'h01, 3'b000, 5'd3, 5'd1, 5'd2);
        bad_op[2] = {12'd1, 5'd1, 3'b001, 5'd3, OP_I};
        for (int e = 0; e < 3; e++) begin
            clr_imem();
            imem[0] = bad_op[e];
            run(done);
            chk($sformatf("illegal%0d_state", e), {30'd0, halted, err}, 32'b11);
            chk($sformatf("illegal%0d_retire", e), 32'(ret_cnt), 32'd0);
        end

        // Reset in the middle of a stalled load: request drops at once, x5 keeps its value
        clr_imem();
        dwait = 10;
        imem[0] = f_addi(5'd5, 5'd0, 12'd7);
        imem[1] = f_lw(5'd5, 5'd0, 12'd16);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin @(negedge clk); found = dmem_req; end
        repeat (2) @(negedge clk);
        chk("rst_mid_req_before", {31'd0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_req_drop", {30'd0, dmem_req, imem_req}, 32'd0);
        repeat (2) @(negedge clk);
        clr_imem();
        dwait = 0;
        imem[0] = f_sw(5'd5, 5'd0, 12'd36);
        rst_n = 1'b1;
        #1 chk("rst_mid_refetch", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h00});
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin @(negedge clk); done = halted; end
        chk("rst_mid_x5_kept", st_data, 32'd7);
        chk("rst_mid_store_addr", {24'd0, st_addr}, 32'd36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
